avalon_copy_host: RTL and testbench

AVALON_COPY_HOST -- requirements
Module: avalon_copy_host

---
 rtl/avalon_copy_pkg.sv | 22 ++
 rtl/avalon_if.sv | 32 +++
 rtl/avalon_copy_host_buffer.sv | 33 +++
 rtl/avalon_copy_host.sv | 193 +++++++++++++++++++
 tb/tb_avalon_copy_host.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/avalon_copy_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : avalon_copy_pkg
//  Description : Shared types and constants for the Avalon-MM copy host.
//  Revision    : 1.0  initial release
// ============================================================================
package avalon_copy_pkg;

    // Bus words are 32 bits wide, so address steps are four bytes per word.
    localparam int BYTES_PER_WORD = 4;

    // Copy engine states, explicitly encoded in three bits.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_REQ   = 3'd1,
        RD_DATA  = 3'd2,
        WR_BURST = 3'd3,
        FINISH   = 3'd4
    } copy_state_t;

endpackage
`default_nettype wire

// File: rtl/avalon_if.sv
`default_nettype none
// ============================================================================
//  Module      : avalon_if
//  Description : Avalon-MM bursting bus bundle with host and agent views.
//  Revision    : 1.0  initial release
// ============================================================================
interface avalon_if #(
    parameter int BURSTCOUNT_W = 4
);
    logic                    clk;
    logic                    reset;
    logic [31:0]             address;
    logic                    read;
    logic                    write;
    logic [BURSTCOUNT_W-1:0] burstcount;
    logic [31:0]             writedata;
    logic [3:0]              byteenable;
    logic [31:0]             readdata;
    logic                    readdatavalid;
    logic                    waitrequest;

    modport host (
        input  clk, reset, readdata, readdatavalid, waitrequest,
        output address, read, write, burstcount, writedata, byteenable
    );

    modport agent (
        input  clk, reset, address, read, write, burstcount, writedata, byteenable,
        output readdata, readdatavalid, waitrequest
    );
endinterface
`default_nettype wire

// File: rtl/avalon_copy_host_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : copy_buffer
//  Description : Burst staging buffer, DEPTH x 32 registers with one write
//                port and one combinational read port. No reset: contents
//                are always written before they are read within a chunk.
//  Revision    : 1.0  initial release
// ============================================================================
module copy_buffer #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [31:0]      i_wr_data,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [31:0]      o_rd_data
);

    logic [31:0] r_mem [DEPTH];

    // Capture one read beat into its slot.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/avalon_copy_host.sv
`default_nettype none
// ============================================================================
//  Module      : avalon_copy_host
//  Description : Avalon-MM host that copies len_words 32-bit words from
//                src_addr to dst_addr in chunks of up to MAX_BURST words:
//                one read burst into a local buffer, then one write burst.
//  Revision    : 1.0  initial release
// ============================================================================
module avalon_copy_host
    import avalon_copy_pkg::*;
#(
    parameter int BURSTCOUNT_W = 4,   // must be >= 2
    parameter int LEN_W        = 16   // must be >  BURSTCOUNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    avalon_if.host           avalon_h,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len_words,
    output logic             busy,
    output logic             done
);

    localparam int                    MAX_BURST     = 1 << (BURSTCOUNT_W - 1);
    localparam int                    IDX_W         = BURSTCOUNT_W - 1;
    localparam logic [LEN_W-1:0]      MAX_BURST_LEN = LEN_W'(MAX_BURST);
    localparam logic [BURSTCOUNT_W-1:0] MAX_BURST_BC = BURSTCOUNT_W'(MAX_BURST);

    copy_state_t             r_state;
    copy_state_t             w_next_state;

    logic [31:0]             r_src;
    logic [31:0]             r_dst;
    logic [LEN_W-1:0]        r_remaining;
    logic [BURSTCOUNT_W-1:0] r_beat;

    logic [BURSTCOUNT_W-1:0] w_chunk;
    logic [LEN_W-1:0]        w_rem_after;
    logic [31:0]             w_step;
    logic                    w_last_beat;
    logic [31:0]             w_buf_rd;
    logic                    w_buf_we;

    logic [31:0]             w_address;
    logic                    w_read;
    logic                    w_write;
    logic [BURSTCOUNT_W-1:0] w_burstcount;
    logic [31:0]             w_writedata;
    logic [3:0]              w_byteenable;
    logic                    w_busy;
    logic                    w_done;

    // The bundle's own clock/reset are not used; this block runs on clk/reset_n.
    logic                    w_unused;
    assign w_unused = &{1'b0, avalon_h.clk, avalon_h.reset};

    // Chunk size follows only r_remaining, which changes solely after the
    // last write beat, so it stays fixed across a chunk's read and write.
    assign w_chunk     = (r_remaining >= MAX_BURST_LEN) ? MAX_BURST_BC
                                                        : r_remaining[BURSTCOUNT_W-1:0];
    assign w_rem_after = r_remaining - LEN_W'(w_chunk);
    assign w_step      = 32'(w_chunk) * 32'(BYTES_PER_WORD);
    assign w_last_beat = (r_beat == (w_chunk - BURSTCOUNT_W'(1)));
    assign w_buf_we    = (r_state == RD_DATA) && avalon_h.readdatavalid;

    copy_buffer #(
        .DEPTH (MAX_BURST),
        .IDX_W (IDX_W)
    ) u_buffer (
        .clk       (clk),
        .i_wr_idx  (r_beat[IDX_W-1:0]),
        .i_wr_data (avalon_h.readdata),
        .i_wr_en   (w_buf_we),
        .i_rd_idx  (r_beat[IDX_W-1:0]),
        .o_rd_data (w_buf_rd)
    );

    // State register; reset abandons any copy in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and bus outputs; outputs are zero outside the active states,
    // so they fall to zero as soon as reset forces IDLE.
    always_comb begin
        w_next_state = r_state;
        w_address    = '0;
        w_read       = 1'b0;
        w_write      = 1'b0;
        w_burstcount = '0;
        w_writedata  = '0;
        w_byteenable = '0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = (len_words == '0) ? FINISH : RD_REQ;
                end
            end
            RD_REQ: begin
                w_busy       = 1'b1;
                w_read       = 1'b1;
                w_address    = r_src;
                w_burstcount = w_chunk;
                if (!avalon_h.waitrequest) begin
                    w_next_state = RD_DATA;
                end
            end
            RD_DATA: begin
                w_busy = 1'b1;
                if (avalon_h.readdatavalid && w_last_beat) begin
                    w_next_state = WR_BURST;
                end
            end
            WR_BURST: begin
                w_busy       = 1'b1;
                w_write      = 1'b1;
                w_address    = r_dst;
                w_burstcount = w_chunk;
                w_writedata  = w_buf_rd;
                w_byteenable = 4'hF;
                if (!avalon_h.waitrequest && w_last_beat) begin
                    w_next_state = (w_rem_after == '0) ? FINISH : RD_REQ;
                end
            end
            FINISH: begin
                w_done       = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Copy bookkeeping: latch the request, count beats, advance pointers per chunk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_src       <= '0;
            r_dst       <= '0;
            r_remaining <= '0;
            r_beat      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_src       <= src_addr;
                        r_dst       <= dst_addr;
                        r_remaining <= len_words;
                        r_beat      <= '0;
                    end
                end
                RD_DATA: begin
                    if (avalon_h.readdatavalid) begin
                        r_beat <= w_last_beat ? '0 : (r_beat + BURSTCOUNT_W'(1));
                    end
                end
                WR_BURST: begin
                    if (!avalon_h.waitrequest) begin
                        if (w_last_beat) begin
                            r_beat      <= '0;
                            r_remaining <= w_rem_after;
                            r_src       <= r_src + w_step;
                            r_dst       <= r_dst + w_step;
                        end else begin
                            r_beat <= r_beat + BURSTCOUNT_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign avalon_h.address    = w_address;
    assign avalon_h.read       = w_read;
    assign avalon_h.write      = w_write;
    assign avalon_h.burstcount = w_burstcount;
    assign avalon_h.writedata  = w_writedata;
    assign avalon_h.byteenable = w_byteenable;
    assign busy                = w_busy;
    assign done                = w_done;

endmodule
`default_nettype wire

// File: tb/tb_avalon_copy_host.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_avalon_copy_host
//  Description : Directed bench for avalon_copy_host with a bursting memory
//                agent, a table of copy vectors and hand-written corner cases.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_avalon_copy_host;

    localparam int BURSTCOUNT_W = 4;
    localparam int LEN_W        = 16;
    localparam int MAX_BURST    = 8;
    localparam int MEM_WORDS    = 256;
    localparam int NUM_VECS     = 6;

    typedef struct {
        logic [31:0] addr;
        int          cnt;
    } burst_t;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        int          len;
        bit          stall;
        int          exp_bursts;
        int          exp_last;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic [31:0]      src_addr = '0;
    logic [31:0]      dst_addr = '0;
    logic [LEN_W-1:0] len_words = '0;
    logic             busy;
    logic             done;

    avalon_if #(.BURSTCOUNT_W(BURSTCOUNT_W)) bus ();
    assign bus.clk   = clk;
    assign bus.reset = ~reset_n;

    avalon_copy_host #(
        .BURSTCOUNT_W (BURSTCOUNT_W),
        .LEN_W        (LEN_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .avalon_h  (bus),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len_words (len_words),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Owned by the main test.
    int  n_vec = 0;
    int  n_err = 0;
    int  epoch = 0;
    int  salt  = 0;
    bit  stall_mode = 1'b0;
    vec_t vecs [NUM_VECS];

    // Owned by the memory agent.
    logic [31:0] wmem     [MEM_WORDS];
    int          wr_epoch [MEM_WORDS];
    burst_t      rd_log [$];
    burst_t      wr_log [$];
    int          done_cnt   = 0;
    int          proto_viol = 0;
    int          rw_cycles  = 0;

    // Source memory content is a pure function of word index and salt.
    function automatic logic [31:0] pat(input int w, input int s);
        logic [7:0] wb;
        logic [7:0] sb;
        wb = w[7:0];
        sb = s[7:0];
        return {8'hC0 ^ sb, wb, ~wb, 8'h5A};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory agent: decides waitrequest and read beats at each falling edge,
    // records accepted bursts, stores write beats and watches the protocol.
    initial begin : agent
        logic [31:0]             prev_addr;
        logic [31:0]             prev_wd;
        logic [BURSTCOUNT_W-1:0] prev_bc;
        logic [31:0]             wr_base;
        logic [31:0]             tmp;
        logic [BURSTCOUNT_W-1:0] wr_bc;
        bit                      prev_rd_stall;
        bit                      prev_wr_stall;
        bit                      rd_out;
        int                      rd_lat;
        int                      wr_left;
        int                      wr_idx;
        int                      rd_q [$];
        prev_addr = '0; prev_wd = '0; prev_bc = '0; wr_base = '0; wr_bc = '0;
        prev_rd_stall = 1'b0; prev_wr_stall = 1'b0; rd_out = 1'b0;
        rd_lat = 0; wr_left = 0; wr_idx = 0;
        bus.waitrequest   = 1'b0;
        bus.readdatavalid = 1'b0;
        bus.readdata      = '0;
        for (int w = 0; w < MEM_WORDS; w++) begin
            wr_epoch[w] = -1;
            wmem[w]     = '0;
        end
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                rd_q.delete();
                rd_out = 1'b0; rd_lat = 0; wr_left = 0; wr_idx = 0;
                prev_rd_stall = 1'b0; prev_wr_stall = 1'b0;
                bus.waitrequest   = 1'b0;
                bus.readdatavalid = 1'b0;
            end else begin
                if (bus.read && bus.write) proto_viol++;
                if (bus.write && bus.byteenable !== 4'hF) proto_viol++;
                if (prev_rd_stall && !(bus.read === 1'b1 && bus.address === prev_addr &&
                                       bus.burstcount === prev_bc)) proto_viol++;
                if (prev_wr_stall && !(bus.write === 1'b1 && bus.address === prev_addr &&
                                       bus.burstcount === prev_bc && bus.writedata === prev_wd))
                    proto_viol++;
                if (bus.read || bus.write) rw_cycles++;
                if (done) begin
                    done_cnt++;
                    if (busy) proto_viol++;
                end

                bus.waitrequest = stall_mode ? 1'($urandom_range(0, 1)) : 1'b0;
                prev_rd_stall = bus.read && bus.waitrequest;
                prev_wr_stall = bus.write && bus.waitrequest;
                prev_addr = bus.address;
                prev_bc   = bus.burstcount;
                prev_wd   = bus.writedata;

                if (rd_q.size() > 0 && rd_lat == 0) begin
                    bus.readdatavalid = 1'b1;
                    bus.readdata      = pat(rd_q.pop_front(), salt);
                    if (rd_q.size() == 0) rd_out = 1'b0;
                end else if (rd_lat > 0) begin
                    rd_lat--;
                    bus.readdatavalid = 1'b0;
                end else if (stall_mode && !rd_out && $urandom_range(0, 3) == 0) begin
                    bus.readdatavalid = 1'b1;      // stray beat, must be ignored
                    bus.readdata      = 32'hDEAD_BEEF;
                end else begin
                    bus.readdatavalid = 1'b0;
                end

                if (bus.read && !bus.waitrequest) begin
                    rd_log.push_back('{addr: bus.address, cnt: int'(bus.burstcount)});
                    for (int k = 0; k < int'(bus.burstcount); k++) begin
                        tmp = (bus.address >> 2) + 32'(k);
                        rd_q.push_back(int'(tmp[7:0]));
                    end
                    rd_lat = 1;
                    rd_out = 1'b1;
                end

                if (bus.write && !bus.waitrequest) begin
                    if (wr_left == 0) begin
                        wr_base = bus.address;
                        wr_bc   = bus.burstcount;
                        wr_left = int'(bus.burstcount);
                        wr_idx  = 0;
                        wr_log.push_back('{addr: bus.address, cnt: int'(bus.burstcount)});
                        if (wr_left == 0) begin
                            proto_viol++;
                            wr_left = 1;
                        end
                    end else if (bus.address !== wr_base || bus.burstcount !== wr_bc) begin
                        proto_viol++;
                    end
                    tmp = (wr_base >> 2) + 32'(wr_idx);
                    wmem[int'(tmp[7:0])]     = bus.writedata;
                    wr_epoch[int'(tmp[7:0])] = epoch;
                    wr_idx++;
                    wr_left--;
                end
            end
        end
    end

    // One complete copy with all its end-of-run comparisons.
    task automatic do_copy(input vec_t v, input string tag, input bit inject);
        int rd0, wr0, d0, p0, timeout, gap, bad, nb;
        int w, ecnt;
        logic [31:0] tmp;
        epoch++;
        salt = epoch;
        stall_mode = v.stall;
        rd0 = rd_log.size(); wr0 = wr_log.size(); d0 = done_cnt; p0 = proto_viol;
        @(negedge clk);
        src_addr = v.src; dst_addr = v.dst; len_words = LEN_W'(v.len); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        if (inject) begin
            repeat (3) @(negedge clk);
            src_addr = 32'h3C0; dst_addr = 32'h080; len_words = 16'd5; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        timeout = 0; gap = 0;
        while (done_cnt == d0 && timeout < 3000) begin
            @(negedge clk);
            if (!busy && !done) gap++;
            timeout++;
        end
        check({tag, "_done_before_timeout"}, 32'(timeout < 3000), 32'd1);
        check({tag, "_busy_held"}, 32'(gap), 32'd0);
        repeat (20) @(negedge clk);
        check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_protocol"}, 32'(proto_viol - p0), 32'd0);

        bad = 0;
        for (int i = 0; i < v.len; i++) begin
            tmp = (v.dst >> 2) + 32'(i);
            w   = int'(tmp[7:0]);
            tmp = (v.src >> 2) + 32'(i);
            if (wr_epoch[w] != epoch || wmem[w] !== pat(int'(tmp[7:0]), salt)) bad++;
        end
        check({tag, "_dst_data_errors"}, 32'(bad), 32'd0);
        tmp = (v.dst >> 2) + 32'(v.len);
        check({tag, "_word_past_end_untouched"}, 32'(wr_epoch[int'(tmp[7:0])] == epoch), 32'd0);
        if (inject) begin
            bad = 0;
            for (int i = 32; i < 37; i++) if (wr_epoch[i] == epoch) bad++;
            check({tag, "_ignored_start_no_writes"}, 32'(bad), 32'd0);
        end

        check({tag, "_read_bursts"},  32'(rd_log.size() - rd0), 32'(v.exp_bursts));
        check({tag, "_write_bursts"}, 32'(wr_log.size() - wr0), 32'(v.exp_bursts));
        bad = 0;
        nb  = v.exp_bursts;
        for (int i = 0; i < nb; i++) begin
            ecnt = (i == nb - 1) ? v.exp_last : MAX_BURST;
            if (rd0 + i < rd_log.size()) begin
                if (rd_log[rd0 + i].addr !== v.src + 32'(32 * i) || rd_log[rd0 + i].cnt != ecnt) bad++;
            end
            if (wr0 + i < wr_log.size()) begin
                if (wr_log[wr0 + i].addr !== v.dst + 32'(32 * i) || wr_log[wr0 + i].cnt != ecnt) bad++;
            end
        end
        check({tag, "_burst_addr_count"}, 32'(bad), 32'd0);
    endtask

    initial begin : main
        int  rw0, d0;
        bit  found;
        vec_t v;

        //          src            dst            len stall bursts last
        vecs[0] = '{32'h0000_0000, 32'h0000_0040,   3, 1'b0, 1, 3};
        vecs[1] = '{32'h0000_0000, 32'h0000_0100,  20, 1'b0, 3, 4};
        vecs[2] = '{32'h0000_0080, 32'h0000_0200,  13, 1'b1, 2, 5};
        vecs[3] = '{32'h0000_0300, 32'h0000_0010,   8, 1'b1, 1, 8};
        vecs[4] = '{32'h0000_0020, 32'h0000_0380,   1, 1'b0, 1, 1};
        vecs[5] = '{32'h0000_0100, 32'h0000_02C0,  16, 1'b1, 2, 8};

        // Reset state.
        @(negedge clk);
        check("reset_read",       32'(bus.read),       32'd0);
        check("reset_write",      32'(bus.write),      32'd0);
        check("reset_busy_done",  32'({busy, done}),   32'd0);
        check("reset_address",    bus.address,         32'd0);
        check("reset_burstcount", 32'(bus.burstcount), 32'd0);
        check("reset_be_wdata",   32'(bus.byteenable) | bus.writedata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < NUM_VECS; i++) begin
            do_copy(vecs[i], $sformatf("vec%0d", i), 1'b0);
        end

        // Zero-length copy: start sampled at the next rising edge, done
        // visible in the following cycle only, and no bus requests at all.
        stall_mode = 1'b0;
        @(negedge clk);
        rw0 = rw_cycles; d0 = done_cnt;
        src_addr = 32'h10; dst_addr = 32'h20; len_words = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("len0_done", 32'(done), 32'd1);
        check("len0_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("len0_done_one_cycle", 32'(done), 32'd0);
        repeat (5) @(negedge clk);
        check("len0_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("len0_no_bus_activity", 32'(rw_cycles - rw0), 32'd0);

        // Start pulsed while busy must be ignored.
        v = '{32'h0000_0040, 32'h0000_0240, 10, 1'b0, 2, 2};
        do_copy(v, "busy_start", 1'b1);

        // Reset asserted during the write burst.
        epoch++;
        salt = epoch;
        stall_mode = 1'b0;
        @(negedge clk);
        src_addr = 32'h0; dst_addr = 32'h200; len_words = 16'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (bus.write) found = 1'b1;
        end
        check("rst_reached_wr_burst", 32'(found), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_mid_read_write", 32'({bus.read, bus.write}), 32'd0);
        check("rst_mid_busy_done",  32'({busy, done}),          32'd0);
        check("rst_mid_address",    bus.address,                32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        v = '{32'h0000_0040, 32'h0000_0300, 5, 1'b1, 1, 5};
        do_copy(v, "after_reset", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
